// File: rtl/csi2_pixel_unpacker.sv
// csi2_pixel_unpacker: takes the D-PHY RX packet stream and turns it into framed
// 4-pixel groups. It drops non-video packets, unpacks RAW8/RAW10/RAW12 payload,
// and derives fv/lv from the FS/FE short packets.
// Optional macro: CSI2_PIXEL_UNPACKER_LINE_CNT_EN adds a per-frame line count on
// line_cnt. Without the macro, line_cnt is tied to zero.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | outside a frame, waiting for FS
// ST_FRAME | inside a frame, waiting for a video long-packet header or FE
// ST_LINE  | collecting payload of the selected video packet, emitting groups
module csi2_pixel_unpacker #(
    parameter int NUM_RX_LANE = 2,
    parameter int RX_GEAR     = 8,
    parameter int PIX_W       = 12
) (
    input  logic                          byte_clk,
    input  logic                          byte_clk_rst_n,
    input  logic [5:0]                    ref_dt,
    input  logic                          sp_en,
    input  logic                          lp_av_en,
    input  logic [5:0]                    dt,
    input  logic [15:0]                   wc,
    input  logic                          payload_en,
    input  logic [NUM_RX_LANE*RX_GEAR-1:0] payload,
    output logic                          fv,
    output logic                          lv,
    output logic                          pix_valid,
    output logic [4*PIX_W-1:0]            pix_data,
    output logic                          pix_sol,
    output logic                          pix_eol,
    output logic                          err_line,
    output logic                          err_dt,
    output logic [15:0]                   line_cnt
);
    localparam int BYTES_IN = NUM_RX_LANE * RX_GEAR / 8;
    localparam int BUF_B    = 2 * ((BYTES_IN > 6) ? BYTES_IN : 6);
    localparam int BUF_W    = 8 * BUF_B;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FRAME = 2'd1;
    localparam logic [1:0] ST_LINE  = 2'd2;

    localparam logic [1:0] M_RAW8  = 2'd0;
    localparam logic [1:0] M_RAW10 = 2'd1;
    localparam logic [1:0] M_RAW12 = 2'd2;

    localparam logic [5:0] DT_FS    = 6'h00;
    localparam logic [5:0] DT_FE    = 6'h01;
    localparam logic [5:0] DT_RAW8  = 6'h2A;
    localparam logic [5:0] DT_RAW10 = 6'h2B;
    localparam logic [5:0] DT_RAW12 = 6'h2C;

    logic [1:0]         state_q, state_d, mode_q, mode_d, ref_mode;
    logic [15:0]        rem_q, rem_d, rem_nxt;
    logic [7:0]         cnt_q, cnt_d, cnt_nxt, g, take, base;
    logic [BUF_W-1:0]   buf_q, buf_d, buf_nxt;
    logic               sol_q, sol_d, ref_ok, fs, fe, emit;
    logic               fv_q, fv_d, lv_q, lv_d, pv_q, pv_d, psol_q, psol_d;
    logic               peol_q, peol_d, eline_q, eline_d, edt_q, edt_d;
    logic [4*PIX_W-1:0] pdata_q, pdata_d, grp_pix;
    logic [47:0]        grp12;

    // Classify the selected video type; unsupported types are rejected at line start
    always_comb begin
        ref_ok   = 1'b1;
        ref_mode = M_RAW8;
        case (ref_dt)
            DT_RAW8:  ref_mode = M_RAW8;
            DT_RAW10: ref_mode = M_RAW10;
            DT_RAW12: ref_mode = M_RAW12;
            default:  ref_ok   = 1'b0;
        endcase
    end

    // Unpack the head of the byte buffer into four MSB-aligned pixels
    always_comb begin
        grp12 = '0;
        case (mode_q)
            M_RAW8: begin
                for (int k = 0; k < 4; k++)
                    grp12[12*k +: 12] = {buf_q[8*k +: 8], 4'b0000};
            end
            M_RAW10: begin
                for (int k = 0; k < 4; k++)
                    grp12[12*k +: 12] = {buf_q[8*k +: 8], buf_q[32+2*k +: 2], 2'b00};
            end
            default: begin
                grp12 = {buf_q[32 +: 8], buf_q[44 +: 4], buf_q[24 +: 8], buf_q[40 +: 4],
                         buf_q[8 +: 8],  buf_q[20 +: 4], buf_q[0 +: 8],  buf_q[16 +: 4]};
            end
        endcase
        for (int k = 0; k < 4; k++)
            grp_pix[PIX_W*k +: PIX_W] = PIX_W'(grp12[12*k +: 12]) << (PIX_W - 12);
    end

    // Buffer arithmetic: consume one group from the head, append this beat's bytes at the tail
    always_comb begin
        g       = (mode_q == M_RAW8) ? 8'd4 : (mode_q == M_RAW10) ? 8'd5 : 8'd6;
        emit    = (cnt_q >= g);
        take    = (rem_q < 16'(BYTES_IN)) ? rem_q[7:0] : 8'(BYTES_IN);
        base    = emit ? (cnt_q - g) : cnt_q;
        rem_nxt = rem_q - {8'd0, take};
        cnt_nxt = base + take;
        if (cnt_nxt > 8'(BUF_B))
            cnt_nxt = 8'(BUF_B);
        buf_nxt = (emit ? (buf_q >> {g, 3'b000}) : buf_q)
                | ((BUF_W'(payload) & ~({BUF_W{1'b1}} << {take, 3'b000})) << {base, 3'b000});
    end

    // Packet decode, line control and output next-state
    always_comb begin
        fs      = sp_en && (dt == DT_FS);
        fe      = sp_en && (dt == DT_FE);
        state_d = state_q;
        mode_d  = mode_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        buf_d   = buf_q;
        sol_d   = sol_q;
        fv_d    = fv_q;
        lv_d    = peol_q ? 1'b0 : lv_q;
        pv_d    = 1'b0;
        pdata_d = pdata_q;
        psol_d  = 1'b0;
        peol_d  = 1'b0;
        eline_d = 1'b0;
        edt_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (fs) begin
                    state_d = ST_FRAME;
                    fv_d    = 1'b1;
                end
            end
            ST_FRAME: begin
                if (fe) begin
                    state_d = ST_IDLE;
                    fv_d    = 1'b0;
                end else if (!sp_en && lp_av_en && (dt == ref_dt)) begin
                    if (ref_ok) begin
                        state_d = ST_LINE;
                        mode_d  = ref_mode;
                        rem_d   = wc;
                        cnt_d   = '0;
                        buf_d   = '0;
                        sol_d   = 1'b1;
                    end else begin
                        edt_d = 1'b1;
                    end
                end
            end
            ST_LINE: begin
                if (fs) begin
                    // frame restart: silently drop the line in progress
                    state_d = ST_FRAME;
                    cnt_d   = '0;
                    buf_d   = '0;
                    rem_d   = '0;
                    lv_d    = 1'b0;
                end else if (fe || (rem_q != 16'd0 && !payload_en)) begin
                    // truncated line: close it without a group
                    state_d = fe ? ST_IDLE : ST_FRAME;
                    fv_d    = fe ? 1'b0 : fv_q;
                    eline_d = 1'b1;
                    peol_d  = lv_q;
                    cnt_d   = '0;
                    buf_d   = '0;
                    rem_d   = '0;
                end else begin
                    rem_d = rem_nxt;
                    cnt_d = cnt_nxt;
                    buf_d = buf_nxt;
                    if (emit) begin
                        pv_d    = 1'b1;
                        pdata_d = grp_pix;
                        psol_d  = sol_q;
                        sol_d   = 1'b0;
                        lv_d    = 1'b1;
                    end
                    if (rem_nxt == 16'd0 && cnt_nxt < g) begin
                        state_d = ST_FRAME;
                        peol_d  = emit | lv_q;
                        eline_d = (cnt_nxt != 8'd0);
                        cnt_d   = '0;
                        buf_d   = '0;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and registered outputs, synchronous active-low reset
    always_ff @(posedge byte_clk) begin
        if (!byte_clk_rst_n) begin
            state_q <= ST_IDLE;
            mode_q  <= M_RAW8;
            rem_q   <= '0;
            cnt_q   <= '0;
            buf_q   <= '0;
            sol_q   <= 1'b0;
            fv_q    <= 1'b0;
            lv_q    <= 1'b0;
            pv_q    <= 1'b0;
            pdata_q <= '0;
            psol_q  <= 1'b0;
            peol_q  <= 1'b0;
            eline_q <= 1'b0;
            edt_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            buf_q   <= buf_d;
            sol_q   <= sol_d;
            fv_q    <= fv_d;
            lv_q    <= lv_d;
            pv_q    <= pv_d;
            pdata_q <= pdata_d;
            psol_q  <= psol_d;
            peol_q  <= peol_d;
            eline_q <= eline_d;
            edt_q   <= edt_d;
        end
    end

    assign fv        = fv_q;
    assign lv        = lv_q;
    assign pix_valid = pv_q;
    assign pix_data  = pdata_q;
    assign pix_sol   = psol_q;
    assign pix_eol   = peol_q;
    assign err_line  = eline_q;
    assign err_dt    = edt_q;

`ifdef CSI2_PIXEL_UNPACKER_LINE_CNT_EN
    logic [15:0] lcnt_q, lcnt_d, lcnt_inc, lcnt_out_q, lcnt_out_d;

    // Count closed lines in the frame, publish the count at FE
    always_comb begin
        lcnt_inc   = (peol_d && lcnt_q != 16'hFFFF) ? lcnt_q + 16'd1 : lcnt_q;
        lcnt_d     = lcnt_inc;
        lcnt_out_d = lcnt_out_q;
        if (fs) begin
            lcnt_d = '0;
        end else if (fe && state_q != ST_IDLE) begin
            lcnt_out_d = lcnt_inc;
            lcnt_d     = '0;
        end
    end

    // Line counter registers
    always_ff @(posedge byte_clk) begin
        if (!byte_clk_rst_n) begin
            lcnt_q     <= '0;
            lcnt_out_q <= '0;
        end else begin
            lcnt_q     <= lcnt_d;
            lcnt_out_q <= lcnt_out_d;
        end
    end

    assign line_cnt = lcnt_out_q;
`else
    assign line_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_csi2_pixel_unpacker.sv
// Directed bench for csi2_pixel_unpacker: three instances (1, 2 and 4 lanes, gear 8)
// share the packet control inputs and each has its own payload bus.
module tb_csi2_pixel_unpacker;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, sp_en, lp_av_en;
    logic [5:0]  ref_dt, dt;
    logic [15:0] wc;
    logic        pe1, pe2, pe4;
    logic [7:0]  pl1;
    logic [15:0] pl2;
    logic [31:0] pl4;

    logic        fv1, lv1, pv1, sol1, eol1, el1, ed1;
    logic        fv2, lv2, pv2, sol2, eol2, el2, ed2;
    logic        fv4, lv4, pv4, sol4, eol4, el4, ed4;
    logic [47:0] pd1, pd2, pd4;
    logic [15:0] lc1, lc2, lc4;

    int checks = 0;
    int errors = 0;

    csi2_pixel_unpacker #(.NUM_RX_LANE(1), .RX_GEAR(8), .PIX_W(12)) u_dut1 (
        .byte_clk(clk), .byte_clk_rst_n(rst_n), .ref_dt(ref_dt), .sp_en(sp_en),
        .lp_av_en(lp_av_en), .dt(dt), .wc(wc), .payload_en(pe1), .payload(pl1),
        .fv(fv1), .lv(lv1), .pix_valid(pv1), .pix_data(pd1), .pix_sol(sol1),
        .pix_eol(eol1), .err_line(el1), .err_dt(ed1), .line_cnt(lc1));

    csi2_pixel_unpacker #(.NUM_RX_LANE(2), .RX_GEAR(8), .PIX_W(12)) u_dut2 (
        .byte_clk(clk), .byte_clk_rst_n(rst_n), .ref_dt(ref_dt), .sp_en(sp_en),
        .lp_av_en(lp_av_en), .dt(dt), .wc(wc), .payload_en(pe2), .payload(pl2),
        .fv(fv2), .lv(lv2), .pix_valid(pv2), .pix_data(pd2), .pix_sol(sol2),
        .pix_eol(eol2), .err_line(el2), .err_dt(ed2), .line_cnt(lc2));

    csi2_pixel_unpacker #(.NUM_RX_LANE(4), .RX_GEAR(8), .PIX_W(12)) u_dut4 (
        .byte_clk(clk), .byte_clk_rst_n(rst_n), .ref_dt(ref_dt), .sp_en(sp_en),
        .lp_av_en(lp_av_en), .dt(dt), .wc(wc), .payload_en(pe4), .payload(pl4),
        .fv(fv4), .lv(lv4), .pix_valid(pv4), .pix_data(pd4), .pix_sol(sol4),
        .pix_eol(eol4), .err_line(el4), .err_dt(ed4), .line_cnt(lc4));

    // event counters for the 2-lane instance, sampled mid-cycle
    int          n_grp2 = 0;
    int          n_eol2 = 0;
    int          n_errl2 = 0;
    logic [47:0] sol_pd2 = '0;
    always @(negedge clk) begin
        if (pv2 === 1'b1) n_grp2++;
        if (eol2 === 1'b1) n_eol2++;
        if (el2 === 1'b1) n_errl2++;
        if (pv2 === 1'b1 && sol2 === 1'b1) sol_pd2 = pd2;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send_fs();
        sp_en = 1'b1; dt = 6'h00;
        cyc();
        sp_en = 1'b0;
    endtask

    task automatic send_fe();
        sp_en = 1'b1; dt = 6'h01;
        cyc();
        sp_en = 1'b0;
    endtask

    task automatic send_lp(input logic [5:0] d, input logic [15:0] w);
        lp_av_en = 1'b1; dt = d; wc = w;
        cyc();
        lp_av_en = 1'b0;
    endtask

    // RAW10 line of 10 bytes on the 2-lane instance, two idle cycles after
    task automatic drive_raw10_line_u2();
        logic [15:0] beats [5];
        beats = '{16'h00FF, 16'h0180, 16'h10E4, 16'h3020, 16'h0040};
        send_lp(6'h2B, 16'd10);
        pe2 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            pl2 = beats[i];
            cyc();
        end
        pe2 = 1'b0;
        cyc();
        cyc();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cyc();
        cyc();
        checks++;
        if ({fv2, lv2, pv2, sol2, eol2, el2, ed2} !== 7'd0) begin
            errors++; $display("FAIL reset_flags got=%b exp=0000000", {fv2, lv2, pv2, sol2, eol2, el2, ed2});
        end
        checks++;
        if (pd2 !== 48'h0) begin
            errors++; $display("FAIL reset_data got=%h exp=0", pd2);
        end
        checks++;
        if (lc2 !== 16'h0) begin
            errors++; $display("FAIL reset_line_cnt got=%h exp=0", lc2);
        end
        rst_n = 1'b1;
        cyc();
    endtask

    task automatic test_raw10();
        ref_dt = 6'h2B;
        send_fs();
        checks++;
        if (fv2 !== 1'b1) begin errors++; $display("FAIL raw10_fv_rise got=%b exp=1", fv2); end
        send_lp(6'h2B, 16'd10);
        pe2 = 1'b1;
        pl2 = 16'h00FF; cyc();
        pl2 = 16'h0180; cyc();
        pl2 = 16'h10E4; cyc();
        checks++;
        if (pv2 !== 1'b0) begin errors++; $display("FAIL raw10_early_valid got=%b exp=0", pv2); end
        pl2 = 16'h3020; cyc();
        checks++;
        if ({pv2, sol2, eol2, lv2} !== 4'b1101) begin
            errors++; $display("FAIL raw10_g1_flags got=%b exp=1101", {pv2, sol2, eol2, lv2});
        end
        checks++;
        if (pd2 !== 48'h01C808004FF0) begin
            errors++; $display("FAIL raw10_g1_data got=%h exp=01c808004ff0", pd2);
        end
        pl2 = 16'h0040; cyc();
        checks++;
        if (pv2 !== 1'b0) begin errors++; $display("FAIL raw10_gap_valid got=%b exp=0", pv2); end
        pe2 = 1'b0; cyc();
        checks++;
        if ({pv2, sol2, eol2, el2} !== 4'b1010) begin
            errors++; $display("FAIL raw10_g2_flags got=%b exp=1010", {pv2, sol2, eol2, el2});
        end
        checks++;
        if (pd2 !== 48'h400300200100) begin
            errors++; $display("FAIL raw10_g2_data got=%h exp=400300200100", pd2);
        end
        cyc();
        checks++;
        if ({lv2, pv2, fv2} !== 3'b001) begin
            errors++; $display("FAIL raw10_lv_fall got=%b exp=001", {lv2, pv2, fv2});
        end
    endtask

    task automatic test_raw12_4lane();
        ref_dt = 6'h2C;
        send_fs();
        send_lp(6'h2C, 16'd12);
        pe4 = 1'b1;
        pl4 = 32'h78563412; cyc();
        pl4 = 32'hCDABBC9A; cyc();
        checks++;
        if (pv4 !== 1'b0) begin errors++; $display("FAIL raw12_early_valid got=%b exp=0", pv4); end
        pl4 = 32'h452301EF; cyc();
        checks++;
        if ({pv4, sol4, eol4} !== 3'b110) begin
            errors++; $display("FAIL raw12_g1_flags got=%b exp=110", {pv4, sol4, eol4});
        end
        checks++;
        if (pd4 !== 48'h9AB78C345126) begin
            errors++; $display("FAIL raw12_g1_data got=%h exp=9ab78c345126", pd4);
        end
        pe4 = 1'b0; cyc();
        checks++;
        if ({pv4, sol4, eol4, el4} !== 4'b1010) begin
            errors++; $display("FAIL raw12_g2_flags got=%b exp=1010", {pv4, sol4, eol4, el4});
        end
        checks++;
        if (pd4 !== 48'h234015CDEABF) begin
            errors++; $display("FAIL raw12_g2_data got=%h exp=234015cdeabf", pd4);
        end
        cyc();
    endtask

    task automatic test_raw8_1lane();
        ref_dt = 6'h2A;
        send_fs();
        send_lp(6'h2A, 16'd8);
        pe1 = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            pl1 = 8'(i);
            cyc();
            if (i == 4) begin
                checks++;
                if (pv1 !== 1'b0) begin errors++; $display("FAIL raw8_early_valid got=%b exp=0", pv1); end
            end
            if (i == 5) begin
                checks++;
                if ({pv1, sol1, eol1} !== 3'b110 || pd1 !== 48'h040030020010) begin
                    errors++; $display("FAIL raw8_g1 got=%b/%h exp=110/040030020010", {pv1, sol1, eol1}, pd1);
                end
            end
        end
        pe1 = 1'b0; cyc();
        checks++;
        if ({pv1, sol1, eol1} !== 3'b101 || pd1 !== 48'h080070060050) begin
            errors++; $display("FAIL raw8_g2 got=%b/%h exp=101/080070060050", {pv1, sol1, eol1}, pd1);
        end
        cyc();
    endtask

    task automatic test_wc7();
        ref_dt = 6'h2B;
        send_lp(6'h2B, 16'd7);
        pe2 = 1'b1;
        pl2 = 16'h00FF; cyc();
        pl2 = 16'h0180; cyc();
        pl2 = 16'h10E4; cyc();
        pl2 = 16'h5520; cyc();
        checks++;
        if ({pv2, sol2, eol2, el2} !== 4'b1111) begin
            errors++; $display("FAIL wc7_flags got=%b exp=1111", {pv2, sol2, eol2, el2});
        end
        checks++;
        if (pd2 !== 48'h01C808004FF0) begin
            errors++; $display("FAIL wc7_data got=%h exp=01c808004ff0", pd2);
        end
        pe2 = 1'b0; cyc();
        checks++;
        if ({el2, pv2, lv2} !== 3'b000) begin
            errors++; $display("FAIL wc7_after got=%b exp=000", {el2, pv2, lv2});
        end
    endtask

    task automatic test_short_packet();
        int g0;
        ref_dt = 6'h2B;
        send_lp(6'h2B, 16'd10);
        pe1 = 1'b1;
        pl1 = 8'hFF; cyc();
        pl1 = 8'h00; cyc();
        pl1 = 8'h80; cyc();
        pe1 = 1'b0; cyc();
        checks++;
        if ({el1, pv1, lv1} !== 3'b100) begin
            errors++; $display("FAIL short_lv0 got=%b exp=100", {el1, pv1, lv1});
        end
        cyc();
        checks++;
        if (el1 !== 1'b0) begin errors++; $display("FAIL short_err_pulse got=%b exp=0", el1); end
        // abort after one group has gone out: eol closes the line with no data
        send_lp(6'h2B, 16'd10);
        pe2 = 1'b1;
        pl2 = 16'h00FF; cyc();
        pl2 = 16'h0180; cyc();
        pl2 = 16'h10E4; cyc();
        pl2 = 16'h3020; cyc();
        pe2 = 1'b0; cyc();
        checks++;
        if ({el2, eol2, pv2, lv2} !== 4'b1101) begin
            errors++; $display("FAIL short_lv1 got=%b exp=1101", {el2, eol2, pv2, lv2});
        end
        cyc();
        checks++;
        if ({lv2, el2, eol2} !== 3'b000) begin
            errors++; $display("FAIL short_lv1_after got=%b exp=000", {lv2, el2, eol2});
        end
        g0 = n_grp2;
        drive_raw10_line_u2();
        checks++;
        if (n_grp2 - g0 !== 2 || sol_pd2 !== 48'h01C808004FF0) begin
            errors++; $display("FAIL short_recover got=%0d/%h exp=2/01c808004ff0", n_grp2 - g0, sol_pd2);
        end
    endtask

    task automatic test_err_dt();
        ref_dt = 6'h2D;
        send_lp(6'h2D, 16'd4);
        checks++;
        if ({ed2, fv2} !== 2'b11) begin errors++; $display("FAIL err_dt_pulse got=%b exp=11", {ed2, fv2}); end
        cyc();
        checks++;
        if (ed2 !== 1'b0) begin errors++; $display("FAIL err_dt_clear got=%b exp=0", ed2); end
        ref_dt = 6'h2B;
    endtask

    task automatic test_frame();
        int g0, e0, x0;
        logic [15:0] exp_lc;
        ref_dt = 6'h2B;
        send_fs();
        g0 = n_grp2; e0 = n_eol2; x0 = n_errl2;
        drive_raw10_line_u2();
        send_lp(6'h12, 16'd4);
        pe2 = 1'b1;
        pl2 = 16'hAAAA; cyc();
        pl2 = 16'h5555; cyc();
        pe2 = 1'b0; cyc();
        checks++;
        if (n_grp2 - g0 !== 2 || fv2 !== 1'b1) begin
            errors++; $display("FAIL frame_embedded got=%0d/%b exp=2/1", n_grp2 - g0, fv2);
        end
        drive_raw10_line_u2();
        drive_raw10_line_u2();
        send_fe();
        checks++;
        if (fv2 !== 1'b0) begin errors++; $display("FAIL frame_fv_fall got=%b exp=0", fv2); end
        checks++;
        if (n_grp2 - g0 !== 6 || n_eol2 - e0 !== 3 || n_errl2 - x0 !== 0) begin
            errors++; $display("FAIL frame_counts got=%0d/%0d/%0d exp=6/3/0", n_grp2 - g0, n_eol2 - e0, n_errl2 - x0);
        end
`ifdef CSI2_PIXEL_UNPACKER_LINE_CNT_EN
        exp_lc = 16'd3;
`else
        exp_lc = 16'd0;
`endif
        checks++;
        if (lc2 !== exp_lc) begin errors++; $display("FAIL frame_line_cnt got=%0d exp=%0d", lc2, exp_lc); end
    endtask

    task automatic test_reset_midline();
        int g0, x0;
        ref_dt = 6'h2B;
        send_fs();
        send_lp(6'h2B, 16'd10);
        pe2 = 1'b1;
        pl2 = 16'h1234; cyc();
        pl2 = 16'h5678; cyc();
        pe2 = 1'b0;
        rst_n = 1'b0;
        cyc();
        checks++;
        if ({fv2, lv2, pv2, sol2, eol2, el2, ed2} !== 7'd0 || pd2 !== 48'h0) begin
            errors++; $display("FAIL midreset_outputs got=%b/%h exp=0000000/0", {fv2, lv2, pv2, sol2, eol2, el2, ed2}, pd2);
        end
        rst_n = 1'b1;
        cyc();
        g0 = n_grp2; x0 = n_errl2;
        send_fs();
        drive_raw10_line_u2();
        checks++;
        if (n_grp2 - g0 !== 2 || sol_pd2 !== 48'h01C808004FF0 || n_errl2 - x0 !== 0) begin
            errors++; $display("FAIL midreset_clean got=%0d/%h/%0d exp=2/01c808004ff0/0", n_grp2 - g0, sol_pd2, n_errl2 - x0);
        end
    endtask

    initial begin
        rst_n = 1'b0; sp_en = 1'b0; lp_av_en = 1'b0; dt = '0; wc = '0; ref_dt = 6'h2B;
        pe1 = 1'b0; pe2 = 1'b0; pe4 = 1'b0; pl1 = '0; pl2 = '0; pl4 = '0;
        cyc();
        test_reset();
        test_raw10();
        test_raw12_4lane();
        test_raw8_1lane();
        test_wc7();
        test_short_packet();
        test_err_dt();
        test_frame();
        test_reset_midline();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
